// File: rtl/screen_char_scan.sv
// Text-mode screen buffer: character RAM with a host write port and a raster scan engine,
// plus a frame-synchronous scroll offset. Bulk-clear sequencer is built when SCREEN_CLEAR_EN is defined.
module screen_char_scan #(
   parameter int                COLS       = 20,
   parameter int                ROWS       = 64,
   parameter int                CHAR_W     = 8,
   parameter int                GLYPH_W    = 8,
   parameter int                GLYPH_H    = 16,
   parameter logic [CHAR_W-1:0] CLEAR_CHAR = 8'h20
) (
   input  logic                                                clk,
   input  logic                                                rst_n,
   input  logic                                                scan_en,
   input  logic                                                wr_en,
   input  logic [$clog2(COLS)-1:0]                             wr_col,
   input  logic [$clog2(ROWS)-1:0]                             wr_row,
   input  logic [CHAR_W-1:0]                                   wr_char,
   input  logic [$clog2(ROWS)-1:0]                             scroll_row,
   input  logic                                                scroll_ld,
   input  logic                                                clear,
   output logic [CHAR_W-1:0]                                   char_out,
   output logic [((GLYPH_W > 1) ? $clog2(GLYPH_W) : 1)-1:0]    glyph_x,
   output logic [((GLYPH_H > 1) ? $clog2(GLYPH_H) : 1)-1:0]    glyph_y,
   output logic                                                char_valid,
   output logic                                                line_start,
   output logic                                                frame_start,
   output logic                                                busy
);

   localparam int CW    = $clog2(COLS);
   localparam int RW    = $clog2(ROWS);
   localparam int GXW   = (GLYPH_W > 1) ? $clog2(GLYPH_W) : 1;
   localparam int GYW   = (GLYPH_H > 1) ? $clog2(GLYPH_H) : 1;
   localparam int DEPTH = ROWS * COLS;
   localparam int AW    = $clog2(DEPTH);

   localparam logic [GXW-1:0] PX_MAX  = GXW'(GLYPH_W - 1);
   localparam logic [CW-1:0]  COL_MAX = CW'(COLS - 1);
   localparam logic [GYW-1:0] GY_MAX  = GYW'(GLYPH_H - 1);
   localparam logic [RW-1:0]  ROW_MAX = RW'(ROWS - 1);
   localparam logic [RW:0]    ROWS_X  = (RW+1)'(ROWS);
   localparam logic [CW:0]    COLS_X  = (CW+1)'(COLS);
   localparam logic [AW-1:0]  COLS_A  = AW'(COLS);
   localparam logic [AW-1:0]  LAST_A  = AW'(DEPTH - 1);

   logic [GXW-1:0]    px_q, px_d;
   logic [CW-1:0]     col_q, col_d;
   logic [GYW-1:0]    gy_q, gy_d;
   logic [RW-1:0]     row_q, row_d;
   logic              px_max, col_max, gy_max, row_max;
   logic              frame_wrap;

   logic [RW-1:0]     scroll_shadow_q, scroll_shadow_d;
   logic [RW-1:0]     scroll_act_q, scroll_act_d;
   logic [RW:0]       scroll_x;
   logic [RW-1:0]     scroll_red;

   logic [RW:0]       row_sum;
   logic [RW-1:0]     phys_row;
   logic [AW-1:0]     rd_addr;

   logic              wr_in_range;
   logic              host_we;
   logic [AW-1:0]     host_addr;

   logic              busy_int;
   logic              clr_we;
   logic [AW-1:0]     clr_addr;

   logic              mem_we;
   logic [AW-1:0]     mem_waddr;
   logic [CHAR_W-1:0] mem_wdata;
   logic [CHAR_W-1:0] mem_q [DEPTH];

   logic [CHAR_W-1:0] char_q;
   logic [GXW-1:0]    glyph_x_q;
   logic [GYW-1:0]    glyph_y_q;
   logic              char_valid_q;
   logic              line_start_q;
   logic              frame_start_q;

   // ---------------- raster counters ----------------
   assign px_max     = (px_q  == PX_MAX);
   assign col_max    = (col_q == COL_MAX);
   assign gy_max     = (gy_q  == GY_MAX);
   assign row_max    = (row_q == ROW_MAX);
   assign frame_wrap = scan_en & px_max & col_max & gy_max & row_max;

   always_comb begin
      px_d  = px_q;
      col_d = col_q;
      gy_d  = gy_q;
      row_d = row_q;
      if (scan_en) begin
         if (!px_max) begin
            px_d = px_q + 1'b1;
         end else begin
            px_d = '0;
            if (!col_max) begin
               col_d = col_q + 1'b1;
            end else begin
               col_d = '0;
               if (!gy_max) begin
                  gy_d = gy_q + 1'b1;
               end else begin
                  gy_d  = '0;
                  row_d = row_max ? '0 : row_q + 1'b1;
               end
            end
         end
      end
   end

   // ---------------- scroll ----------------
   // Shadow input is at most 2^RW-1 < 2*ROWS, so one conditional subtract reduces it.
   assign scroll_x   = {1'b0, scroll_row};
   assign scroll_red = (scroll_x >= ROWS_X) ? RW'(scroll_x - ROWS_X) : scroll_row;

   always_comb begin
      scroll_shadow_d = scroll_shadow_q;
      scroll_act_d    = scroll_act_q;
      if (scroll_ld) begin
         scroll_shadow_d = scroll_red;
      end
      // Active offset only changes at the frame boundary, so a frame never tears.
      if (frame_wrap) begin
         scroll_act_d = scroll_shadow_q;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         px_q            <= '0;
         col_q           <= '0;
         gy_q            <= '0;
         row_q           <= '0;
         scroll_shadow_q <= '0;
         scroll_act_q    <= '0;
      end else begin
         px_q            <= px_d;
         col_q           <= col_d;
         gy_q            <= gy_d;
         row_q           <= row_d;
         scroll_shadow_q <= scroll_shadow_d;
         scroll_act_q    <= scroll_act_d;
      end
   end

   // ---------------- address generation ----------------
   assign row_sum  = {1'b0, row_q} + {1'b0, scroll_act_q};
   assign phys_row = (row_sum >= ROWS_X) ? RW'(row_sum - ROWS_X) : row_sum[RW-1:0];
   assign rd_addr  = AW'(phys_row) * COLS_A + AW'(col_q);

   assign wr_in_range = ({1'b0, wr_row} < ROWS_X) && ({1'b0, wr_col} < COLS_X);
   assign host_we     = wr_en & wr_in_range & ~busy_int;
   assign host_addr   = AW'(wr_row) * COLS_A + AW'(wr_col);

   // ---------------- clear sequencer ----------------
`ifdef SCREEN_CLEAR_EN
   // state | meaning
   // IDLE  | no clear running, host writes accepted
   // CLR   | writing CLEAR_CHAR to clr_addr_q, one cell per cycle, host writes dropped
   typedef enum logic {S_IDLE, S_CLR} clr_state_t;

   clr_state_t    state_q, state_d;
   logic [AW-1:0] clr_addr_q, clr_addr_d;

   always_comb begin
      state_d    = state_q;
      clr_addr_d = clr_addr_q;
      clr_we     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (clear) begin
               state_d    = S_CLR;
               clr_addr_d = '0;
            end
         end
         S_CLR: begin
            clr_we = 1'b1;
            if (clr_addr_q == LAST_A) begin
               state_d    = S_IDLE;
               clr_addr_d = '0;
            end else begin
               clr_addr_d = clr_addr_q + 1'b1;
            end
         end
         default: begin
            state_d    = S_IDLE;
            clr_addr_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         clr_addr_q <= '0;
      end else begin
         state_q    <= state_d;
         clr_addr_q <= clr_addr_d;
      end
   end

   assign busy_int = (state_q == S_CLR);
   assign clr_addr = clr_addr_q;
`else
   logic unused_clear;

   assign unused_clear = clear;
   assign busy_int     = 1'b0;
   assign clr_we       = 1'b0;
   assign clr_addr     = '0;
`endif

   // ---------------- character RAM ----------------
   assign mem_we    = clr_we | host_we;
   assign mem_waddr = clr_we ? clr_addr : host_addr;
   assign mem_wdata = clr_we ? CLEAR_CHAR : wr_char;

   // Contents are deliberately not reset; the nonblocking write gives read-before-write.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   // ---------------- output stage ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         char_q        <= '0;
         glyph_x_q     <= '0;
         glyph_y_q     <= '0;
         char_valid_q  <= 1'b0;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         char_valid_q <= scan_en;
         if (scan_en) begin
            char_q        <= mem_q[rd_addr];
            glyph_x_q     <= px_q;
            glyph_y_q     <= gy_q;
            line_start_q  <= (px_q == '0) && (col_q == '0);
            frame_start_q <= (px_q == '0) && (col_q == '0) && (gy_q == '0) && (row_q == '0);
         end
      end
   end

   assign char_out    = char_q;
   assign glyph_x     = glyph_x_q;
   assign glyph_y     = glyph_y_q;
   assign char_valid  = char_valid_q;
   assign line_start  = line_start_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_int;

endmodule
